// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and helpers for the AXI read-port arbiter.
package axi_read_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;
  localparam int MAX_REQ    = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_t;

  // One-hot to binary index; OR-reduction is safe because the input is one-hot.
  function automatic logic [2:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Round-robin picker: search starts one past the last completed owner.
module axi_read_arbiter_rr #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 update_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         grant_o
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d, idx;

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    grant_o = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % N);
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
      end
    end
  end

  // Pointer moves only when a burst finishes, never on grant.
  assign ptr_d = update_i ? IW'((int'(last_i) + 1) % N) : ptr_q;

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master port among NUM_REQ requesters, one burst at a time.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = DEF_ADDR_W,
  parameter int AXI_DATA_WIDTH = DEF_DATA_W
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_arvalid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]              req_arlen,
  output logic [NUM_REQ-1:0]                req_arready,
  output logic [NUM_REQ-1:0]                req_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]         req_rdata,
  input  logic [NUM_REQ-1:0]                req_rready,
  output logic                              req_rlast,
  output logic [AXI_ADDR_WIDTH-1:0]         m_araddr,
  output logic [7:0]                        m_arlen,
  output logic [2:0]                        m_arprot,
  output logic                              m_arvalid,
  input  logic                              s_arready,
  input  logic [AXI_DATA_WIDTH-1:0]         s_rdata,
  input  logic                              s_rvalid,
  output logic                              m_rready
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t                state_q, state_d;
  logic [IDX_W-1:0]          owner_q, owner_d, pick;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]        grant;
  logic                      burst_done;

  axi_read_arbiter_rr #(.N(NUM_REQ)) u_rr (
    .clk      (clk),
    .rst_n    (reset_n),
    .req_i    (req_arvalid),
    .update_i (burst_done),
    .last_i   (owner_q),
    .grant_o  (grant)
  );

  assign pick     = IDX_W'(oh_to_idx(MAX_REQ'(grant)));
  assign m_araddr = araddr_q;
  assign m_arlen  = arlen_q;
  assign m_arprot = 3'b000;

  // Next-state and channel routing; address/length come from latched registers
  // so requester changes after the IDLE sample are ignored.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    beat_cnt_d  = beat_cnt_q;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    req_arready = '0;
    req_rvalid  = '0;
    req_rdata   = '0;
    req_rlast   = 1'b0;
    burst_done  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req_arvalid) begin
          owner_d  = pick;
          araddr_d = req_araddr[int'(pick)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          arlen_d  = req_arlen[int'(pick)*8 +: 8];
          state_d  = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        m_arvalid = 1'b1;
        if (s_arready) begin
          req_arready[owner_q] = 1'b1;
          beat_cnt_d           = arlen_q;
          state_d              = ARB_DATA;
        end
      end
      ARB_DATA: begin
        m_rready            = req_rready[owner_q];
        req_rvalid[owner_q] = s_rvalid;
        req_rdata           = s_rdata;
        req_rlast           = s_rvalid && (beat_cnt_q == 8'd0);
        if (s_rvalid && m_rready) begin
          if (beat_cnt_q == 8'd0) begin
            burst_done = 1'b1;
            state_d    = ARB_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, owner, latched request and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Read data outside a granted burst is a slave protocol error.
  a_rvalid_only_in_data: assert property (@(posedge clk) disable iff (!reset_n)
    s_rvalid |-> state_q == ARB_DATA);
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized scoreboard bench for axi_read_arbiter with a simple AXI slave model.
module tb_axi_read_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req_arvalid, req_arready, req_rvalid, req_rready;
  logic [NR*AW-1:0]  req_araddr;
  logic [NR*8-1:0]   req_arlen;
  logic [DW-1:0]     req_rdata, s_rdata;
  logic              req_rlast, m_arvalid, s_arready, s_rvalid, m_rready;
  logic [AW-1:0]     m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arprot;

  always #5 clk = ~clk;

  axi_read_arbiter #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .req_rready(req_rready), .req_rlast(req_rlast),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arprot(m_arprot), .m_arvalid(m_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rvalid(s_rvalid), .m_rready(m_rready)
  );

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } burst_t;

  burst_t exp_q[$];
  burst_t cur;
  int  n_chk = 0, n_fail = 0;
  int  done_cnt = 0, mon_beat = 0, cyc = 0, done_cyc = 0, mdl_ptr = 0;
  bit  in_burst = 0, b2b = 0, prev_pend = 0;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_len;
  int  ar_delay = 0, rv_pct = 100;
  bit  rr_rand = 0;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
    return a ^ (DW'(b) * 32'h0101_0101);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters drop their request once the address is accepted.
  logic [NR-1:0] seen_rdy;
  always begin
    @(negedge clk); seen_rdy = req_arready;
    @(posedge clk); #1;
    req_arvalid = req_arvalid & ~seen_rdy;
  end

  // Requester data-ready: all ready, or random per cycle.
  always begin
    @(posedge clk); #1;
    req_rready = rr_rand ? NR'($urandom) : '1;
  end

  // Slave model: one outstanding burst, configurable arready delay and rvalid density.
  bit            sl_busy = 0, ar_hs, r_hs, arv;
  logic [AW-1:0] sl_addr, ar_addr;
  logic [7:0]    sl_len, ar_len;
  int            sl_beat = 0, sl_wait = 0;
  always begin
    @(negedge clk);
    ar_hs = m_arvalid & s_arready; r_hs = s_rvalid & m_rready; arv = m_arvalid;
    ar_addr = m_araddr; ar_len = m_arlen;
    @(posedge clk); #1;
    if (!reset_n) begin
      sl_busy = 0; s_rvalid = 0; s_arready = 0; sl_wait = 0;
    end else begin
      if (sl_busy && r_hs) begin
        sl_beat++; s_rvalid = 0;
        if (sl_beat > int'(sl_len)) sl_busy = 0;
      end
      if (ar_hs) begin
        sl_busy = 1; sl_addr = ar_addr; sl_len = ar_len; sl_beat = 0; sl_wait = 0;
      end
      if (sl_busy) begin
        s_arready = 0;
        if (!s_rvalid && $urandom_range(1, 100) <= rv_pct) begin
          s_rvalid = 1; s_rdata = beat_data(sl_addr, sl_beat);
        end
      end else begin
        sl_wait   = arv ? sl_wait + 1 : 0;
        s_arready = (sl_wait >= ar_delay);
      end
    end
  end

  // Monitor: pops expected bursts on address handshakes and checks every beat.
  always @(negedge clk) begin
    if (!reset_n) begin
      in_burst = 0; b2b = 0; prev_pend = 0;
    end else begin
      if (in_burst) begin
        chk("m_rready_follow", m_rready, req_rready[cur.id]);
        chk("rlast", req_rlast, s_rvalid && (mon_beat == int'(cur.len)));
        if (s_rvalid) begin
          chk("rvalid_route", req_rvalid, NR'(1) << cur.id);
          chk("rdata", req_rdata, beat_data(cur.addr, mon_beat));
        end
        if (s_rvalid && m_rready) begin
          if (mon_beat == int'(cur.len)) begin
            in_burst = 0; done_cnt++;
            if (exp_q.size() > 0) begin b2b = 1; done_cyc = cyc; end
          end else mon_beat++;
        end
      end else begin
        chk("m_rready_idle", m_rready, 0);
        chk("rvalid_idle", req_rvalid, 0);
      end
      if (m_arvalid) begin
        chk("arprot", m_arprot, 0);
        if (b2b) begin chk("b2b_gap", cyc - done_cyc, 2); b2b = 0; end
        if (prev_pend) begin
          chk("araddr_stable", m_araddr, prev_addr);
          chk("arlen_stable", m_arlen, prev_len);
        end
        if (s_arready) begin
          prev_pend = 0;
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_grant: got arready %0h expected none", req_arready);
          end else begin
            cur = exp_q.pop_front();
            chk("araddr", m_araddr, cur.addr);
            chk("arlen", m_arlen, cur.len);
            chk("arready_owner", req_arready, NR'(1) << cur.id);
            in_burst = 1; mon_beat = 0;
          end
        end else begin
          chk("arready_hold", req_arready, 0);
          prev_pend = 1; prev_addr = m_araddr; prev_len = m_arlen;
        end
      end else begin
        if (prev_pend) chk("arvalid_held", m_arvalid, 1);
        prev_pend = 0;
        chk("arready_noaddr", req_arready, 0);
      end
    end
  end

  // Reference model: a static request set is served in circular order starting
  // one past the last completed requester.
  task automatic start_round(input logic [NR-1:0] mask, input int len_mode,
                             input logic [AW-1:0] faddr, output int target);
    int last, cnt;
    burst_t b;
    @(posedge clk); #1;
    last = -1; cnt = 0;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (mdl_ptr + k) % NR;
      if (mask[i]) begin
        b.id   = i;
        b.addr = (faddr != '0) ? faddr : (AW'($urandom) & ~AW'(15));
        b.len  = (len_mode < 0) ? 8'($urandom_range(0, 7)) : 8'(len_mode);
        req_araddr[i*AW +: AW] = b.addr;
        req_arlen[i*8 +: 8]    = b.len;
        req_arvalid[i]         = 1'b1;
        exp_q.push_back(b);
        last = i; cnt++;
      end
    end
    if (last >= 0) mdl_ptr = (last + 1) % NR;
    target = done_cnt + cnt;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
    chk("burst_completion", done_cnt, target);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_m_arvalid"}, m_arvalid, 0);
    chk({tag, "_m_rready"}, m_rready, 0);
    chk({tag, "_req_arready"}, req_arready, 0);
    chk({tag, "_req_rvalid"}, req_rvalid, 0);
    chk({tag, "_req_rlast"}, req_rlast, 0);
    chk({tag, "_req_rdata"}, req_rdata, 0);
    chk({tag, "_m_araddr"}, m_araddr, 0);
    chk({tag, "_m_arlen"}, m_arlen, 0);
  endtask

  initial begin
    int t, n;
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '1;
    s_arready = 0; s_rvalid = 0; s_rdata = '0;
    repeat (3) @(negedge clk);
    chk_cleared("rst");
    chk("rst_arprot", m_arprot, 0);
    #2 reset_n = 1;

    // All four together, single beats: order 0,1,2,3; then 0 and 2.
    start_round(4'b1111, 0, '0, t); wait_done(t, 500);
    start_round(4'b0101, 0, '0, t); wait_done(t, 500);

    // Single requester 0 at 0x1000, 4 beats; m_arvalid one cycle after request.
    start_round(4'b0001, 3, 32'h1000, t);
    @(negedge clk); chk("arvalid_latency_idle", m_arvalid, 0);
    @(negedge clk); chk("arvalid_latency_addr", m_arvalid, 1);
    wait_done(t, 500);

    // Address backpressure and data-ready toggling.
    ar_delay = 5; rr_rand = 1; rv_pct = 70;
    start_round(4'b1000, 5, '0, t); wait_done(t, 1000);
    ar_delay = 0;

    // 256-beat burst from requester 2; a short request from 3 during DATA is ignored.
    start_round(4'b0100, 255, '0, t);
    n = 0;
    while (!in_burst && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_arvalid[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_arvalid[3] = 1'b0;
    wait_done(t, 20000);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      ar_delay = $urandom_range(0, 3);
      rv_pct   = $urandom_range(40, 100);
      rr_rand  = 1'($urandom_range(0, 1));
      start_round(NR'($urandom_range(1, 15)), -1, '0, t);
      wait_done(t, 3000);
    end

    // Reset mid-burst after requester 1 has moved the pointer.
    ar_delay = 0; rv_pct = 100; rr_rand = 0;
    start_round(4'b0010, -1, '0, t); wait_done(t, 500);
    start_round(4'b0001, 3, '0, t);
    n = 0;
    while (!(in_burst && mon_beat == 1) && n < 200) begin @(negedge clk); #1; n++; end
    chk("reached_beat2", mon_beat, 1);
    @(posedge clk); #3 reset_n = 0;
    #1 chk_cleared("async_rst");
    exp_q.delete(); mdl_ptr = 0; req_arvalid = '0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    start_round(4'b1010, -1, '0, t); wait_done(t, 500);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
